// File: rtl/neuron_mac_sequencer.sv
// Fully-connected neuron sequencer: streams activations against a registered weight ROM,
// accumulates signed Q-format products, adds bias, saturates and hands off one result.
module neuron_mac_sequencer #(
  parameter int NUM_WEIGHT = 30,
  parameter int ADDR_W     = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 12,
  parameter int ACC_W      = 2*DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              w_ren,
  output logic [ADDR_W-1:0] w_radd,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_BIAS,
    S_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHT - 1);

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     r_state;
  state_t                     w_next;
  logic        [ADDR_W-1:0]   r_cnt;
  logic signed [ACC_W-1:0]    r_acc;
  logic        [DATA_W-1:0]   r_x;
  logic                       r_xv;
  logic                       r_out_valid;
  logic        [DATA_W-1:0]   r_out_data;

  logic                              w_accept;
  logic                              w_last;
  logic signed [2*DATA_W-1:0]        w_x_ext;
  logic signed [2*DATA_W-1:0]        w_w_ext;
  logic signed [2*DATA_W-1:0]        w_prod;
  logic signed [DATA_W+FRAC_BITS-1:0] w_bias_sh;
  logic signed [ACC_W:0]             w_sum;
  logic signed [ACC_W:0]             w_shr;
  logic        [DATA_W-1:0]          w_sat;

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_RUN);
  assign w_accept  = in_valid && (r_state == S_RUN);
  assign w_ren     = w_accept;
  assign w_radd    = r_cnt;
  assign w_last    = (r_cnt == LAST_IDX);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Weight arrives one cycle after its read, so it pairs with the activation latched on accept.
  assign w_x_ext = (2*DATA_W)'($signed(r_x));
  assign w_w_ext = (2*DATA_W)'($signed(w_data));
  assign w_prod  = w_x_ext * w_w_ext;

  assign w_bias_sh = $signed({bias, {FRAC_BITS{1'b0}}});
  assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_bias_sh);
  assign w_shr     = w_sum >>> FRAC_BITS;

  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_shr < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_BIAS;
      S_BIAS:  w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_xv        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_xv <= 1'b0;
      if (r_xv) begin
        r_acc <= r_acc + ACC_W'(w_prod);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_x  <= in_data;
            r_xv <= 1'b1;
            if (!w_last) begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        S_BIAS: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer with a 4-weight neuron and registered ROM model.
module tb_neuron_mac_sequencer;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        w_ren;
  logic [1:0]  w_radd;
  logic [15:0] w_data;
  logic [15:0] bias;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  logic [15:0] tb_x [NW];
  logic [15:0] tb_w [NW];
  logic [15:0] sb [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_addr = 0;
  int          rd_cnt   = 0;

  neuron_mac_sequencer #(
    .NUM_WEIGHT(NW),
    .DATA_W(16),
    .FRAC_BITS(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_ren(w_ren), .w_radd(w_radd), .w_data(w_data), .bias(bias),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_ren) w_data <= tb_w[w_radd];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model();
    longint acc = 0;
    for (int i = 0; i < NW; i++) begin
      acc += longint'($signed(tb_x[i])) * longint'($signed(tb_w[i]));
    end
    acc += longint'($signed(bias)) * 4096;
    acc = acc >>> 12;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (w_ren) begin
        check("w_radd", {30'd0, w_radd}, exp_addr);
        exp_addr++;
        rd_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else check("out_data", out_data, sb.pop_front());
      end
    end
  end

  task automatic load(input logic [15:0] x0, x1, x2, x3, w0, w1, w2, w3, b);
    tb_x[0] = x0; tb_x[1] = x1; tb_x[2] = x2; tb_x[3] = x3;
    tb_w[0] = w0; tb_w[1] = w1; tb_w[2] = w2; tb_w[3] = w3;
    bias = b;
  endtask

  task automatic do_run(input bit bubble, input bit hold);
    int          idx = 0;
    int          cyc = 0;
    bit          acc_b;
    bit          tog = 1'b0;
    logic [15:0] exp_v;
    exp_v = model();
    sb.push_back(exp_v);
    exp_addr  = 0;
    rd_cnt    = 0;
    out_ready = !hold;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < NW && cyc < 40) begin
      in_valid = bubble ? tog : 1'b1;
      tog      = !tog;
      in_data  = tb_x[idx];
      @(negedge clk);
      acc_b = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc_b) idx++;
    end
    in_valid = 1'b0;
    check("beats", idx, NW);
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("out_valid_seen", out_valid, 1);
    if (!bubble) check("latency", cyc, NW + 2);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        start = (k == 1);
        @(negedge clk);
        check("hold_data", out_data, exp_v);
        check("hold_busy", busy, 1);
        check("hold_valid", out_valid, 1);
        @(posedge clk); #1;
      end
      start     = 1'b1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after", busy, 0);
    check("out_valid_drop", out_valid, 0);
    check("reads", rd_cnt, NW);
    out_ready = 1'b1;
  endtask

  task automatic do_reset_mid();
    exp_addr  = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = tb_x[0];
    @(posedge clk); #1;
    in_data = tb_x[1];
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_radd", {30'd0, w_radd}, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_w_ren", w_ren, 0);
    check("arst_w_radd", {30'd0, w_radd}, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    bias = '0; out_ready = 1'b1; w_data = '0;
    for (int i = 0; i < NW; i++) begin
      tb_x[i] = '0;
      tb_w[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_w_ren", w_ren, 0);
    check("rst_w_radd", {30'd0, w_radd}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    in_valid = 1'b1;
    @(negedge clk);
    check("idle_w_ren", w_ren, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("idle_ignore_valid", busy, 0);

    load(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000);
    do_run(1'b0, 1'b0);
    do_run(1'b1, 1'b0);
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000);
    do_run(1'b0, 1'b0);
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000);
    do_run(1'b0, 1'b0);
    load(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'hF000);
    do_run(1'b0, 1'b0);
    load(16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    do_run(1'b0, 1'b0);
    load(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000);
    do_run(1'b0, 1'b1);
    do_reset_mid();
    do_run(1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      do_run(r[0], 1'b0);
    end

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
